// File: rtl/asyn_fifo_wr_arb_if.sv
// ----------------------------------------------------------------------------
// asyn_fifo_wr_arb_if
// Bundle of requester-side and FIFO-side signals for the async FIFO
// write-port arbiter.
//   req_i    : per-requester request (data slice valid while high)
//   last_i   : per-requester end-of-burst marker
//   data_i   : packed requester words, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   full_n_i : FIFO has space (1 = not full)
//   gnt_o    : one-hot grant, word of owner consumed at next clk_wr_i edge
//   wr_o     : FIFO write strobe
//   data_o   : FIFO write data
//   src_o    : current / last owner index
//   busy_o   : a burst is in progress
//   beat_o   : words accepted in the current burst
// Modport slave is the arbiter; master is the requesters + FIFO side.
// ----------------------------------------------------------------------------
interface asyn_fifo_wr_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 18,
    parameter int MAX_BURST  = 8
);
    localparam int SRC_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ-1:0]            last_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
    logic                          full_n_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic                          wr_o;
    logic [DATA_WIDTH-1:0]         data_o;
    logic [SRC_W-1:0]              src_o;
    logic                          busy_o;
    logic [BEAT_W-1:0]             beat_o;

    modport master (
        output req_i, last_i, data_i, full_n_i,
        input  gnt_o, wr_o, data_o, src_o, busy_o, beat_o
    );

    modport slave (
        input  req_i, last_i, data_i, full_n_i,
        output gnt_o, wr_o, data_o, src_o, busy_o, beat_o
    );
endinterface

// File: rtl/asyn_fifo_wr_arb.sv
// ----------------------------------------------------------------------------
// asyn_fifo_wr_arb
// Round-robin burst arbiter sharing the single async-FIFO write port among
// NUM_REQ requesters, in the clk_wr_i domain. A burst ends on last_i of the
// owner, on reaching MAX_BURST words, or when the owner drops its request.
// Writes stall on a full FIFO so no word is dropped or duplicated.
// Ports:
//   clk_wr_i : write clock (same as FIFO write clock)
//   reset    : asynchronous, active-low reset
//   bus      : slave side of asyn_fifo_wr_arb_if (requests, data, FIFO
//              flag in; grant, write strobe, data, status out)
// ----------------------------------------------------------------------------
module asyn_fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 18,
    parameter int MAX_BURST  = 8
) (
    input  logic                     clk_wr_i,
    input  logic                     reset,
    asyn_fifo_wr_arb_if.slave        bus
);
    localparam int SRC_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]        state_q,  state_d;
    logic [SRC_W-1:0]  owner_q,  owner_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0] beat_q,   beat_d;

    logic              accept;
    logic              found;
    logic [SRC_W-1:0]  winner;
    logic [SRC_W-1:0]  cand;
    logic [NUM_REQ-1:0] gnt;

    // Round-robin search starting just after the last owner; modulo keeps
    // non-power-of-two requester counts correct.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = SRC_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && bus.req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign accept = (state_q == ST_XFER) && bus.req_i[owner_q] && bus.full_n_i;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        if (state_q == ST_IDLE) begin
            if (found) begin
                state_d = ST_XFER;
                owner_d = winner;
                beat_d  = '0;
            end
        end else begin
            // Withdrawal ends the burst even while stalled on full.
            if (!bus.req_i[owner_q]) begin
                state_d  = ST_IDLE;
                rr_ptr_d = owner_q;
                beat_d   = '0;
            end else if (bus.full_n_i) begin
                if (bus.last_i[owner_q] || (int'(beat_q) + 1 == MAX_BURST)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_q;
                    beat_d   = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_wr_i or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= SRC_W'(NUM_REQ - 1);
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (accept) begin
            gnt[owner_q] = 1'b1;
        end
    end

    assign bus.gnt_o  = gnt;
    assign bus.wr_o   = accept;
    assign bus.data_o = accept ? bus.data_i[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.src_o  = owner_q;
    assign bus.busy_o = (state_q == ST_XFER);
    assign bus.beat_o = beat_q;

endmodule

// File: tb/tb_asyn_fifo_wr_arb.sv
// ----------------------------------------------------------------------------
// tb_asyn_fifo_wr_arb
// Self-checking bench for asyn_fifo_wr_arb (NUM_REQ=4, DATA_WIDTH=18,
// MAX_BURST=8): vector table, hand-written corner sequences and random
// traffic, all compared against a behavioural model of the arbitration rules.
// ----------------------------------------------------------------------------
module tb_asyn_fifo_wr_arb;
    localparam int N  = 4;
    localparam int DW = 18;
    localparam int MB = 8;

    logic clk;
    logic reset;

    asyn_fifo_wr_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) bus ();

    asyn_fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk_wr_i (clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Behavioural model: is a burst running, who owns it, who had it last,
    // how many words it has moved.
    bit m_busy;
    int m_owner;
    int m_last_owner;
    int m_beat;

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic [N-1:0]  last;
        logic          full_n;
        logic [DW-1:0] word;
        logic [N-1:0]  gnt;
        logic          wr;
        logic [DW-1:0] data;
        logic [1:0]    src;
        logic          busy;
        logic [3:0]    beat;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_busy       = 1'b0;
        m_owner      = 0;
        m_last_owner = N - 1;
        m_beat       = 0;
    endtask

    // Apply inputs at negedge, compare outputs to model mid-cycle, then move
    // the model to the state the coming posedge will produce.
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] last,
                        input logic full_n, input logic [N*DW-1:0] data);
        logic          acc;
        logic [N-1:0]  e_gnt;
        logic [DW-1:0] e_data;
        @(negedge clk);
        bus.req_i    = req;
        bus.last_i   = last;
        bus.full_n_i = full_n;
        bus.data_i   = data;
        #2;
        acc    = m_busy && req[m_owner] && full_n;
        e_gnt  = acc ? N'(1 << m_owner) : '0;
        e_data = acc ? DW'(data >> (m_owner * DW)) : '0;
        chk("model", {bus.gnt_o, bus.wr_o, bus.data_o, bus.src_o, bus.busy_o, bus.beat_o},
            {e_gnt, acc, e_data, 2'(m_owner), m_busy, 4'(m_beat)});
        if (!m_busy) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_last_owner + i) % N;
                if (!m_busy && req[k]) begin
                    m_busy  = 1'b1;
                    m_owner = k;
                    m_beat  = 0;
                end
            end
        end else if (!req[m_owner]) begin
            m_busy = 1'b0; m_last_owner = m_owner; m_beat = 0;
        end else if (full_n) begin
            m_beat++;
            if (last[m_owner] || m_beat == MB) begin
                m_busy = 1'b0; m_last_owner = m_owner; m_beat = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        bus.req_i    = '0;
        bus.last_i   = '0;
        bus.full_n_i = 1'b1;
        bus.data_i   = '0;
        #2;
        chk("reset_outputs", {bus.gnt_o, bus.wr_o, bus.data_o, bus.src_o, bus.busy_o, bus.beat_o}, '0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    function automatic logic [N*DW-1:0] spread(input logic [DW-1:0] w);
        logic [N*DW-1:0] d;
        for (int k = 0; k < N; k++) d[k*DW +: DW] = w + DW'(k * 18'h1000);
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [N*DW-1:0] d;
        logic [1:0]      srcq [$];
        logic [DW-1:0]   wq   [$];
        int              idx;

        checks = 0; failures = 0;
        reset = 1'b0;
        bus.req_i = '0; bus.last_i = '0; bus.full_n_i = 1'b1; bus.data_i = '0;
        model_reset();

        // rst, req, last, full_n, word | gnt, wr, data, src, busy, beat
        tbl[0]  = '{1'b1, 4'b0010, 4'b0000, 1'b1, 18'h000A1, 4'b0000, 1'b0, 18'h00000, 2'd0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 4'b0010, 4'b0000, 1'b1, 18'h000A1, 4'b0010, 1'b1, 18'h010A1, 2'd1, 1'b1, 4'd0};
        tbl[2]  = '{1'b0, 4'b0010, 4'b0000, 1'b1, 18'h000B2, 4'b0010, 1'b1, 18'h010B2, 2'd1, 1'b1, 4'd1};
        tbl[3]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 18'h000C3, 4'b0010, 1'b1, 18'h010C3, 2'd1, 1'b1, 4'd2};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 18'h00000, 4'b0000, 1'b0, 18'h00000, 2'd1, 1'b0, 4'd0};
        tbl[5]  = '{1'b1, 4'b1011, 4'b1111, 1'b1, 18'h00055, 4'b0000, 1'b0, 18'h00000, 2'd0, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 4'b1011, 4'b1111, 1'b1, 18'h00055, 4'b0001, 1'b1, 18'h00055, 2'd0, 1'b1, 4'd0};
        tbl[7]  = '{1'b0, 4'b1011, 4'b1111, 1'b1, 18'h00066, 4'b0000, 1'b0, 18'h00000, 2'd0, 1'b0, 4'd0};
        tbl[8]  = '{1'b0, 4'b1011, 4'b1111, 1'b1, 18'h00066, 4'b0010, 1'b1, 18'h01066, 2'd1, 1'b1, 4'd0};
        tbl[9]  = '{1'b0, 4'b1011, 4'b1111, 1'b1, 18'h00077, 4'b0000, 1'b0, 18'h00000, 2'd1, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 4'b1011, 4'b1111, 1'b1, 18'h00077, 4'b1000, 1'b1, 18'h03077, 2'd3, 1'b1, 4'd0};
        tbl[11] = '{1'b0, 4'b1011, 4'b1111, 1'b1, 18'h00088, 4'b0000, 1'b0, 18'h00000, 2'd3, 1'b0, 4'd0};
        tbl[12] = '{1'b0, 4'b1011, 4'b1111, 1'b1, 18'h00088, 4'b0001, 1'b1, 18'h00088, 2'd0, 1'b1, 4'd0};

        for (int r = 0; r < 13; r++) begin
            if (tbl[r].rst) do_reset();
            step(tbl[r].req, tbl[r].last, tbl[r].full_n, spread(tbl[r].word));
            chk($sformatf("table_row%0d", r),
                {bus.gnt_o, bus.wr_o, bus.data_o, bus.src_o, bus.busy_o, bus.beat_o},
                {tbl[r].gnt, tbl[r].wr, tbl[r].data, tbl[r].src, tbl[r].busy, tbl[r].beat});
        end

        // Burst cap: requester 2 streams without last, requester 0 waits.
        do_reset();
        srcq.delete();
        step(4'b0100, 4'b0000, 1'b1, spread(18'h00011));
        for (int c = 1; c <= 12; c++) begin
            step(4'b0101, 4'b0001, 1'b1, spread(DW'(c)));
            if (bus.wr_o) srcq.push_back(bus.src_o);
            if (c <= 8) chk($sformatf("cap_beat%0d", c), 64'(bus.beat_o), 64'(c - 1));
            if (c == 9) chk("cap_beat_cleared", 64'(bus.beat_o), 64'd0);
        end
        chk("cap_write_count", 64'(srcq.size()), 64'd10);
        if (srcq.size() == 10) begin
            for (int i = 0; i < 8; i++) chk($sformatf("cap_src%0d", i), 64'(srcq[i]), 64'd2);
            chk("cap_src_next", 64'(srcq[8]), 64'd0);
            chk("cap_src_resume", 64'(srcq[9]), 64'd2);
        end

        // Full stall: 4 cycles of full after word 2 of a 5-word burst.
        do_reset();
        wq.delete();
        idx = 1;
        for (int c = 0; c <= 10; c++) begin
            d = '0;
            d[1*DW +: DW] = DW'(18'h100 + idx);
            step(4'b0010, (idx == 5) ? 4'b0010 : 4'b0000, !(c >= 3 && c <= 6), d);
            if (bus.wr_o) wq.push_back(bus.data_o);
            if (c >= 3 && c <= 6) begin
                chk($sformatf("stall_wr_c%0d", c), {bus.wr_o, bus.gnt_o}, 64'd0);
                chk($sformatf("stall_beat_c%0d", c), 64'(bus.beat_o), 64'd2);
            end
            if (bus.gnt_o[1]) idx++;
        end
        chk("stall_write_count", 64'(wq.size()), 64'd5);
        if (wq.size() == 5)
            for (int i = 0; i < 5; i++)
                chk($sformatf("stall_word%0d", i + 1), 64'(wq[i]), 64'(18'h101 + i));

        // Withdrawal by owner 3 after 2 words; rr pointer must move to 3.
        do_reset();
        step(4'b0010, 4'b0010, 1'b1, spread(18'h00021));
        step(4'b0010, 4'b0010, 1'b1, spread(18'h00021));
        step(4'b1000, 4'b0000, 1'b1, spread(18'h00031));
        step(4'b1000, 4'b0000, 1'b1, spread(18'h00032));
        step(4'b1000, 4'b0000, 1'b1, spread(18'h00033));
        step(4'b0000, 4'b0000, 1'b1, spread(18'h00034));
        chk("withdraw_no_write", {bus.wr_o, bus.gnt_o}, 64'd0);
        step(4'b1111, 4'b0000, 1'b1, spread(18'h00035));
        chk("withdraw_idle", 64'(bus.busy_o), 64'd0);
        step(4'b1111, 4'b1111, 1'b1, spread(18'h00036));
        chk("withdraw_rr_next", {bus.gnt_o, bus.src_o}, {4'b0001, 2'd0});

        // Asynchronous reset in the middle of a granted cycle.
        do_reset();
        step(4'b0001, 4'b0000, 1'b1, spread(18'h00041));
        step(4'b0001, 4'b0000, 1'b1, spread(18'h00042));
        chk("pre_reset_grant", 64'(bus.gnt_o), 64'b0001);
        #1;
        reset = 1'b0;
        bus.req_i = '0;
        #1;
        chk("async_reset_drop", {bus.gnt_o, bus.wr_o, bus.busy_o}, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(4'b0001, 4'b0000, 1'b1, spread(18'h00043));
        step(4'b0001, 4'b0000, 1'b1, spread(18'h00044));
        chk("post_reset_grant", 64'(bus.gnt_o), 64'b0001);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] rq;
            logic [N-1:0] ls;
            rq = N'($urandom_range(0, 15));
            if (m_busy && $urandom_range(0, 9) != 0) rq[m_owner] = 1'b1;
            ls = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
            d[31:0]  = $urandom;
            d[63:32] = $urandom;
            d[71:64] = 8'($urandom);
            step(rq, ls, ($urandom_range(0, 3) != 0), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
